// File: rtl/dmem_io_responder.sv
// Data-bus responder: word RAM plus an I/O page (LED, cycle counter, TX byte FIFO).
// Reads are combinational from pre-edge state; writes commit on the rising edge.
module dmem_io_responder #(
  parameter int unsigned              ADDR_WIDTH = 16,
  parameter int unsigned              DATA_WIDTH = 32,
  parameter int unsigned              RAM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-9:0]    IO_PAGE    = 8'hFF,
  parameter int unsigned              FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  wrEnable,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic [7:0]            led,
  output logic [7:0]            txData,
  output logic                  txValid,
  input  logic                  txReady
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PtrW:0] FullCount = (PtrW+1)'(FIFO_DEPTH);

  localparam logic [7:0] OffLed    = 8'h00;
  localparam logic [7:0] OffCycle  = 8'h04;
  localparam logic [7:0] OffTxData = 8'h08;
  localparam logic [7:0] OffStatus = 8'h0C;

  logic [DATA_WIDTH-1:0] ram [RAM_WORDS];
  logic [7:0]            fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0]       rdPtr, wrPtr;
  logic [PtrW:0]         count;
  logic                  overflow;
  logic [31:0]           cycleCount;

  logic                  ioSel;
  logic [7:0]            offset;
  logic [RamAw-1:0]      ramIdx;
  logic                  fifoFull, fifoEmpty;
  logic                  pop, pushReq, pushOk;
  logic [7:0]            statusByte;

  assign ioSel     = (addr[ADDR_WIDTH-1:8] == IO_PAGE);
  assign offset    = addr[7:0];
  assign ramIdx    = addr[RamAw+1:2];

  assign fifoFull  = (count == FullCount);
  assign fifoEmpty = (count == '0);
  assign txValid   = !fifoEmpty;
  assign txData    = fifoMem[rdPtr];

  assign pop     = txValid && txReady;
  assign pushReq = wrEnable && ioSel && (offset == OffTxData);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pushOk  = pushReq && (!fifoFull || pop);

  assign statusByte = {4'(count), 1'b0, overflow, fifoEmpty, fifoFull};

  always_comb begin
    rdData = '0;
    if (ioSel) begin
      case (offset)
        OffLed:    rdData = DATA_WIDTH'(led);
        OffCycle:  rdData = DATA_WIDTH'(cycleCount);
        OffStatus: rdData = DATA_WIDTH'(statusByte);
        default:   rdData = '0;
      endcase
    end else begin
      rdData = ram[ramIdx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wrEnable && !ioSel) ram[ramIdx] <= wrData;
    if (!rst && pushOk) fifoMem[wrPtr] <= wrData[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led        <= '0;
      cycleCount <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wrEnable && ioSel && offset == OffLed) led <= wrData[7:0];

      if (wrEnable && ioSel && offset == OffCycle) cycleCount <= '0;
      else                                          cycleCount <= cycleCount + 32'd1;

      if (pop)    rdPtr <= rdPtr + 1'b1;
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pushReq && !pushOk) overflow <= 1'b1;
      else if (wrEnable && ioSel && offset == OffStatus && wrData[2]) overflow <= 1'b0;
    end
  end

endmodule

// File: doc/dmem_io_responder.md
# dmem_io_responder

Responder end of the CPU data bus: answers the core's data address, write data and write enable with same-cycle read data, so the single-cycle core needs no stalls. Decodes each access into a word RAM or a small memory-mapped I/O page. The I/O page holds an LED register, a free-running cycle counter and a byte transmit FIFO. The FIFO drains through a valid/ready stream port toward a serial or debug sink.

## Interface
- ADDR_WIDTH, 16, byte address width of the data bus
- DATA_WIDTH, 32, data word width
- RAM_WORDS, 1024, RAM depth in words, power of two
- IO_PAGE, 8'hFF, value of addr[ADDR_WIDTH-1:8] that selects the I/O page
- FIFO_DEPTH, 4, TX FIFO entries, power of two

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset; synchronous, active-high
- addr  in  ADDR_WIDTH  byte address from the core
- wrData  in  DATA_WIDTH  store data from the core
- wrEnable  in  1  store strobe; the write commits at the next rising edge
- rdData  out  DATA_WIDTH  load data for addr, combinational, same cycle
- led  out  8  LED register
- txData  out  8  FIFO head byte
- txValid  out  1  FIFO non-empty
- txReady  in  1  sink accepts txData this cycle

## Operation
- Decode:
  - addr[ADDR_WIDTH-1:8]==IO_PAGE selects I/O.
  - Any other address selects RAM at word index addr[log2(RAM_WORDS)+1:2]. Higher bits are ignored, so the RAM aliases (wraps).
  - addr[1:0] is ignored everywhere. All accesses are full-word.
- RAM: write-first is not required. A read in the same cycle as a write to the same word returns the old contents. RAM has no reset; contents after reset are undefined.
- I/O registers, selected by addr[7:0]:
  - 0x00 LED: R/W. Writes take wrData[7:0]. Reads return the value zero-extended.
  - 0x04 CYCLE: reads return the 32-bit counter. The counter increments every cycle and wraps 0xFFFFFFFF->0. Any write loads 0 in place of the increment.
  - 0x08 TXDATA: writes push wrData[7:0] into the FIFO. Reads return 0.
  - 0x0C STATUS: reads return bit0 full, bit1 empty, bit2 overflow (sticky), bits[7:4] occupancy count, and 0 elsewhere. Writing with wrData[2]=1 clears overflow. Other bits are read-only.
  - Any other offset reads 0; writes to it are ignored.
- FIFO:
  - Circular buffer with read pointer, write pointer and count (0..FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH.
  - Pop occurs when txValid && txReady.
  - Push is accepted when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle.
  - A rejected push drops the byte and sets overflow.
  - Simultaneous accepted push and pop leaves count unchanged.
  - Pop on empty cannot occur, because txValid is 0.
- txData is the head entry. It must hold stable while txValid=1 and txReady=0.

## Timing
- Reset (rst=1 at an edge) gives:
  - led=0, CYCLE=0, FIFO empty (count=0, pointers 0), overflow=0, txValid=0.
  - txData is don't-care while txValid=0.
  - rst has priority over wrEnable in the same cycle; the write is discarded.
- Read latency is 0 cycles: rdData follows addr combinationally. The state it reflects is the state before this cycle's edge.
- Write latency: state changes at the edge that ends the wrEnable cycle. It is visible to reads in the following cycle.
- The cycle after reset, CYCLE reads 0. It reads N after N further edges without rst.
- A push is visible on txValid/txData in the cycle after the push edge, so empty->valid takes 1 cycle.
- Status bits reflect the registered count. They are never combinationally influenced by this cycle's push or pop.
- Reset mid-stream flushes the FIFO. Bytes not yet handshaked are lost, and txValid is 0 in the next cycle.

## Test plan
- Reset then idle: led=0, txValid=0. Read 0xFF0C -> 0x00000002. Read 0xFF04 at the 5th cycle after reset release -> 4.
- RAM: write 0xDEADBEEF to 0x0010, then read 0x0010 and its alias 0x1010 -> 0xDEADBEEF. Write and read 0x0014 in the same cycle -> old value.
- LED: write 0x1234_56A5 to 0xFF00 -> led=0xA5 next cycle, and a read returns 0x000000A5. Write with rst=1 in the same cycle -> led stays 0.
- FIFO fill with txReady=0:
  - Push 0x11, 0x22, 0x33, 0x44, 0x55. The 5th push is dropped, and STATUS reads 0x00000045 (full, overflow, count 4).
  - Raise txReady: 0x11, 0x22, 0x33, 0x44 come out on consecutive cycles, then txValid=0 and STATUS reads 0x00000006.
  - Write 0x4 to 0xFF0C: overflow clears, and STATUS reads 0x00000002.
- Full-FIFO push with a simultaneous pop: the push is accepted, count stays 4, overflow stays 0, and the pushed byte emerges 4th after the current head.
- CYCLE: write any value to 0xFF04 at counter value 100 -> next read 0, then 1. Force the counter to 0xFFFFFFFF -> it reads 0 the next cycle.
